// File: rtl/decoder_cpu.sv
// Instruction-word decoder: slices a 32-bit code into opcode, func, immediate
// and address fields, registering them on every enabled clock edge.
module decoder_cpu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] code,
  input  logic        en_de,
  output logic [5:0]  opcode_cpu,
  output logic [1:0]  func_cpu,
  output logic [23:0] addr_cpu,
  output logic [7:0]  imm_cpu,
  output logic        valid_de
);

  logic [5:0]  opcode_r;
  logic [1:0]  func_r;
  logic [23:0] addr_r;
  logic [7:0]  imm_r;
  logic        valid_r;

  // Field capture on enabled edges; fields hold otherwise, valid pulses per decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_r <= 6'd0;
      func_r   <= 2'd0;
      addr_r   <= 24'd0;
      imm_r    <= 8'd0;
      valid_r  <= 1'b0;
    end else if (en_de) begin
      opcode_r <= code[7:2];
      func_r   <= code[1:0];
      addr_r   <= code[31:8];
      imm_r    <= code[15:8];
      valid_r  <= 1'b1;
    end else begin
      valid_r  <= 1'b0;
    end
  end

  assign opcode_cpu = opcode_r;
  assign func_cpu   = func_r;
  assign addr_cpu   = addr_r;
  assign imm_cpu    = imm_r;
  assign valid_de   = valid_r;

endmodule

// File: tb/tb_decoder_cpu.sv
// Self-checking bench for decoder_cpu: directed vector table, reset sequences,
// and randomized stimulus against an arithmetic reference model.
module tb_decoder_cpu;

  logic        clk;
  logic        rst_n;
  logic [31:0] code;
  logic        en_de;
  logic [5:0]  opcode_cpu;
  logic [1:0]  func_cpu;
  logic [23:0] addr_cpu;
  logic [7:0]  imm_cpu;
  logic        valid_de;

  int checks;
  int failures;

  // reference model state (plain integers)
  int unsigned m_op, m_func, m_imm, m_addr, m_valid;

  typedef struct {
    logic        en;
    logic [31:0] code;
    int unsigned op;
    int unsigned func;
    int unsigned imm;
    int unsigned addr;
    int unsigned valid;
  } vec_t;

  vec_t vecs [7];

  decoder_cpu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code       (code),
    .en_de      (en_de),
    .opcode_cpu (opcode_cpu),
    .func_cpu   (func_cpu),
    .addr_cpu   (addr_cpu),
    .imm_cpu    (imm_cpu),
    .valid_de   (valid_de)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int unsigned op, input int unsigned fn,
                         input int unsigned imm, input int unsigned addr, input int unsigned vld);
    chk({tag, ".opcode"}, 32'(opcode_cpu), op);
    chk({tag, ".func"},   32'(func_cpu),   fn);
    chk({tag, ".imm"},    32'(imm_cpu),    imm);
    chk({tag, ".addr"},   32'(addr_cpu),   addr);
    chk({tag, ".valid"},  32'(valid_de),   vld);
  endtask

  task automatic model_step(input logic en, input logic [31:0] c);
    int unsigned w;
    w = c;
    if (en) begin
      m_func  = w % 4;
      m_op    = (w / 4) % 64;
      m_imm   = (w / 256) % 256;
      m_addr  = w / 256;
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
  endtask

  task automatic model_reset();
    m_op = 0; m_func = 0; m_imm = 0; m_addr = 0; m_valid = 0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_reset();

    vecs[0] = '{1'b1, 32'h0001_0200, 32'h00, 32'd0, 32'h02, 32'h000102, 32'd1};
    vecs[1] = '{1'b1, 32'hA5C3_F0FF, 32'h3F, 32'd3, 32'hF0, 32'hA5C3F0, 32'd1};
    vecs[2] = '{1'b0, 32'h1234_5678, 32'h3F, 32'd3, 32'hF0, 32'hA5C3F0, 32'd0};
    vecs[3] = '{1'b1, 32'h0000_0004, 32'h01, 32'd0, 32'h00, 32'h000000, 32'd1};
    vecs[4] = '{1'b1, 32'h0000_0007, 32'h01, 32'd3, 32'h00, 32'h000000, 32'd1};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'h01, 32'd3, 32'h00, 32'h000000, 32'd0};
    vecs[6] = '{1'b1, 32'h8000_0001, 32'h00, 32'd1, 32'h00, 32'h800000, 32'd1};

    // asynchronous reset with no clock edge involved
    rst_n = 1'b1;
    en_de = 1'b1;
    code  = 32'hDEAD_BEEF;
    #1 rst_n = 1'b0;
    #1 chk_all("reset_async", 0, 0, 0, 0, 0);

    // unknown inputs during reset must not reach outputs
    code  = 32'bx;
    en_de = 1'bx;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_all("reset_x", 0, 0, 0, 0, 0);
    en_de = 1'b0;
    code  = 32'h0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("post_reset_idle", 0, 0, 0, 0, 0);

    // directed vector table
    for (int i = 0; i < 7; i++) begin
      en_de = vecs[i].en;
      code  = vecs[i].code;
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), vecs[i].op, vecs[i].func, vecs[i].imm,
              vecs[i].addr, vecs[i].valid);
    end
    m_op = vecs[6].op; m_func = vecs[6].func; m_imm = vecs[6].imm;
    m_addr = vecs[6].addr; m_valid = vecs[6].valid;

    // code toggling while disabled has no effect
    en_de = 1'b0;
    for (int i = 0; i < 3; i++) begin
      code = $urandom;
      #2;
      chk_all("disabled_comb", m_op, m_func, m_imm, m_addr, m_valid);
      @(posedge clk); #1;
      model_step(1'b0, code);
      chk_all("disabled_hold", m_op, m_func, m_imm, m_addr, m_valid);
    end

    // mid-operation reset between two enabled decodes
    en_de = 1'b1;
    code  = 32'h1357_9BDF;
    @(posedge clk); #1;
    model_step(1'b1, code);
    chk_all("mid_pre", m_op, m_func, m_imm, m_addr, m_valid);
    code  = 32'h2468_ACE0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("mid_rst_now", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk_all("mid_rst_edge", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    code  = 32'hCAFE_0A0E;
    @(posedge clk); #1;
    model_step(1'b1, code);
    chk_all("mid_post", m_op, m_func, m_imm, m_addr, m_valid);

    // randomized stimulus against the reference model
    for (int i = 0; i < 400; i++) begin
      en_de = 1'($urandom_range(0, 1));
      code  = $urandom;
      @(posedge clk); #1;
      model_step(en_de, code);
      chk_all("rand", m_op, m_func, m_imm, m_addr, m_valid);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
